bw_clk_gclk_ratio_div: RTL and testbench
========================================

BW_CLK_GCLK_RATIO_DIV -- requirements
Module: bw_clk_gclk_ratio_div

Interface
REQ-001 SHALL have parameter JBUS_DIV_RST, default 4, jbus divide ratio loaded at reset.
REQ-002 SHALL have parameter DDR_DIV_RST, default 2, ddr divide ratio loaded at reset.
REQ-003 SHALL have port rclk, input, 1, the single clock of the block (cmp-domain global clock).
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port cfg_req, input, 1, request to change ratios; held high until cfg_ack.
REQ-006 SHALL have port cfg_jbus_div, input, 5, requested jbus ratio.
REQ-007 SHALL have port cfg_ddr_div, input, 5, requested ddr ratio.
REQ-008 SHALL have port cfg_ack, output, 1, one-cycle pulse: new ratios are in effect.
REQ-009 SHALL have port jbus_clk_out, output, 1, divided jbus clock feeding the gclk inverter stage jbus input.
REQ-010 SHALL have port ddr_clk_out, output, 1, divided ddr clock feeding the gclk inverter stage ddr input.
REQ-011 SHALL have port gclk_sync, output, 1, pulse marking coincident jbus/ddr/cmp edge.

Function
REQ-012 SHALL keep per-domain counter cnt_x (5 bits) counting 0..Nx-1 each rclk cycle, then wrapping to 0.
REQ-013 SHALL register outputs with one-cycle latency: x_clk_out(t+1) = (cnt_x(t) < (Nx+1)>>1).
REQ-014 SHALL treat any requested or parameter ratio of 0 or 1 as 2; valid range 2..31.
REQ-015 SHALL implement FSM IDLE, PEND, DONE.
REQ-016 IDLE: on cfg_req=1, capture cfg_jbus_div/cfg_ddr_div into shadow registers, go PEND.
REQ-017 PEND: shadow values SHALL NOT change when cfg_* inputs change.
REQ-018 PEND: in the cycle with cnt_jbus==Njbus-1 and cnt_ddr==Nddr-1 (alignment point), load shadows into Njbus/Nddr, both counters wrap to 0, go DONE.
REQ-019 SHALL assert cfg_ack for exactly the cycle after the alignment-point load.
REQ-020 DONE: return to IDLE only after sampling cfg_req=0; a held cfg_req SHALL NOT produce a second ack.
REQ-021 SHALL never shorten or stretch a phase other than at the alignment point; output waveforms are glitch-free registered values.
REQ-022 gclk_sync(t+1) SHALL be 1 iff cnt_jbus(t)==0 and cnt_ddr(t)==0 and reset(t)==0.

Reset
REQ-023 While reset=1: counters 0, Njbus=JBUS_DIV_RST, Nddr=DDR_DIV_RST (clamped), FSM IDLE, shadows cleared.
REQ-024 While reset=1 and in the first cycle after release: jbus_clk_out, ddr_clk_out, cfg_ack, gclk_sync all 0.
REQ-025 Reset in PEND or DONE SHALL abandon the request with no cfg_ack; ratios revert to parameter defaults.

Configuration
REQ-026 With GCLK_DIV_SYNC_EN defined, gclk_sync SHALL be driven per REQ-022.
REQ-027 Without GCLK_DIV_SYNC_EN, gclk_sync SHALL be tied 0, the port SHALL remain, and no sync logic SHALL exist.

Structure
REQ-028 Package bw_clk_gclk_pkg SHALL hold: divider width (5), minimum ratio (2), FSM state enum.
REQ-029 Sub-module bw_clk_gclk_div_cnt SHALL implement one counter plus output flop; instantiated twice (jbus, ddr).

Verification
REQ-030 Reset release with defaults 4/2 -> from cycle 1 after release: jbus_clk_out 1,1,0,0 repeating; ddr_clk_out 1,0 repeating; gclk_sync every 4th cycle starting at cycle 1.
REQ-031 cfg_req with jbus=6, ddr=3 at cycle 10 -> ratios switch at the next alignment point (cnt_jbus=3, cnt_ddr=1); one cfg_ack pulse; then jbus 1,1,1,0,0,0 and ddr 1,1,0 from the wrap.
REQ-032 cfg_req with jbus=0, ddr=1 -> both ratios behave as 2; ack issued; both outputs toggle 1,0.
REQ-033 cfg_req held high for 50 cycles after ack -> exactly one cfg_ack; a new request is accepted only after cfg_req drops for ≥1 cycle.
REQ-034 reset asserted 2 cycles into PEND -> no cfg_ack; after release, waveforms match REQ-030.
REQ-035 Build without GCLK_DIV_SYNC_EN -> gclk_sync constant 0 for all scenarios above; clock outputs unchanged.

Source files
------------

// File: rtl/bw_clk_gclk_pkg.sv
// Shared definitions for the gclk ratio divider: divider width, minimum ratio,
// configuration FSM states and the ratio clamp helper.
package bw_clk_gclk_pkg;

   localparam int DIV_W = 5;
   localparam logic [DIV_W-1:0] DIV_MIN = 5'd2;
   localparam logic [DIV_W-1:0] DIV_ONE = 5'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } cfg_state_t;

   // Ratios of 0 and 1 cannot produce a two-phase clock, so they run as 2.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/bw_clk_gclk_div_cnt.sv
// One divider domain: modulo-ratio counter plus the registered clock output,
// high for the first ceil(ratio/2) counts of each period.
module bw_clk_gclk_div_cnt
   import bw_clk_gclk_pkg::*;
(
   input  logic             rclk,
   input  logic             reset,
   input  logic [DIV_W-1:0] ratio,
   output logic [DIV_W-1:0] cnt,
   output logic             clk_out
);

   logic [DIV_W:0] half;
   logic           at_end;

   assign half   = ({1'b0, ratio} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   assign at_end = (cnt >= (ratio - DIV_ONE));

   always_ff @(posedge rclk) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else begin
         cnt     <= at_end ? '0 : cnt + DIV_ONE;
         clk_out <= ({1'b0, cnt} < half);
      end
   end

endmodule

// File: rtl/bw_clk_gclk_ratio_div.sv
// jbus/ddr clock ratio divider with handshaked ratio change at the common
// alignment point. Define GCLK_DIV_SYNC_EN to drive gclk_sync; otherwise it is 0.
module bw_clk_gclk_ratio_div
   import bw_clk_gclk_pkg::*;
#(
   parameter int JBUS_DIV_RST = 4,
   parameter int DDR_DIV_RST  = 2
) (
   input  logic       rclk,
   input  logic       reset,
   input  logic       cfg_req,
   input  logic [4:0] cfg_jbus_div,
   input  logic [4:0] cfg_ddr_div,
   output logic       cfg_ack,
   output logic       jbus_clk_out,
   output logic       ddr_clk_out,
   output logic       gclk_sync
);

   localparam logic [DIV_W-1:0] JBUS_RST_N = clamp_div(DIV_W'(JBUS_DIV_RST));
   localparam logic [DIV_W-1:0] DDR_RST_N  = clamp_div(DIV_W'(DDR_DIV_RST));

   cfg_state_t       state;
   logic [DIV_W-1:0] n_jbus, n_ddr;
   logic [DIV_W-1:0] sh_jbus, sh_ddr;
   logic [DIV_W-1:0] cnt_jbus, cnt_ddr;
   logic             align;

   // Both counters sit on their last count, so both wrap together this edge.
   assign align = (state == ST_PEND) &&
                  (cnt_jbus == (n_jbus - DIV_ONE)) &&
                  (cnt_ddr  == (n_ddr  - DIV_ONE));

   always_ff @(posedge rclk) begin
      if (reset) begin
         state   <= ST_IDLE;
         n_jbus  <= JBUS_RST_N;
         n_ddr   <= DDR_RST_N;
         sh_jbus <= '0;
         sh_ddr  <= '0;
         cfg_ack <= 1'b0;
      end else begin
         cfg_ack <= align;
         case (state)
            ST_IDLE: begin
               if (cfg_req) begin
                  sh_jbus <= clamp_div(cfg_jbus_div);
                  sh_ddr  <= clamp_div(cfg_ddr_div);
                  state   <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (align) begin
                  n_jbus <= sh_jbus;
                  n_ddr  <= sh_ddr;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!cfg_req) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   bw_clk_gclk_div_cnt u_jbus (
      .rclk    (rclk),
      .reset   (reset),
      .ratio   (n_jbus),
      .cnt     (cnt_jbus),
      .clk_out (jbus_clk_out)
   );

   bw_clk_gclk_div_cnt u_ddr (
      .rclk    (rclk),
      .reset   (reset),
      .ratio   (n_ddr),
      .cnt     (cnt_ddr),
      .clk_out (ddr_clk_out)
   );

`ifdef GCLK_DIV_SYNC_EN
   always_ff @(posedge rclk) begin
      if (reset) gclk_sync <= 1'b0;
      else       gclk_sync <= (cnt_jbus == '0) && (cnt_ddr == '0);
   end
`else
   assign gclk_sync = 1'b0;
`endif

endmodule

// File: tb/tb_bw_clk_gclk_ratio_div.sv
// Directed bench for bw_clk_gclk_ratio_div: default ratios, ratio change,
// clamping, held request, re-request and reset during a pending request.
module tb_bw_clk_gclk_ratio_div;

   logic       rclk = 1'b0;
   logic       reset;
   logic       cfg_req;
   logic [4:0] cfg_jbus_div;
   logic [4:0] cfg_ddr_div;
   logic       cfg_ack;
   logic       jbus_clk_out;
   logic       ddr_clk_out;
   logic       gclk_sync;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 rclk = ~rclk;
   always @(posedge rclk) cyc <= cyc + 1;

   bw_clk_gclk_ratio_div dut (
      .rclk         (rclk),
      .reset        (reset),
      .cfg_req      (cfg_req),
      .cfg_jbus_div (cfg_jbus_div),
      .cfg_ddr_div  (cfg_ddr_div),
      .cfg_ack      (cfg_ack),
      .jbus_clk_out (jbus_clk_out),
      .ddr_clk_out  (ddr_clk_out),
      .gclk_sync    (gclk_sync)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ej, input logic ed,
                          input logic es, input logic ea);
      logic s_exp;
`ifdef GCLK_DIV_SYNC_EN
      s_exp = es;
`else
      s_exp = es & 1'b0;
`endif
      chk({tag, ".jbus"}, jbus_clk_out, ej);
      chk({tag, ".ddr"},  ddr_clk_out,  ed);
      chk({tag, ".sync"}, gclk_sync,    s_exp);
      chk({tag, ".ack"},  cfg_ack,      ea);
   endtask

   // Patterns read left to right, first bit = first cycle checked.
   task automatic seq(input string tag, input int n, input logic [31:0] ej,
                      input logic [31:0] ed, input logic [31:0] es,
                      input logic [31:0] ea);
      for (int i = 0; i < n; i++) begin
         @(negedge rclk);
         chk_all(tag, ej[n-1-i], ed[n-1-i], es[n-1-i], ea[n-1-i]);
      end
   endtask

   initial begin
      reset        = 1'b1;
      cfg_req      = 1'b0;
      cfg_jbus_div = 5'd0;
      cfg_ddr_div  = 5'd0;

      repeat (2) @(negedge rclk);
      chk_all("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge rclk);
      reset = 1'b0;
      chk_all("rel", 1'b0, 1'b0, 1'b0, 1'b0);

      // Defaults 4/2
      seq("dflt", 8, 8'b11001100, 8'b10101010, 8'b10001000, 8'b0);
      seq("pre",  2, 2'b11, 2'b10, 2'b10, 2'b00);

      // Request 6/3; inputs change while pending must not matter
      cfg_req      = 1'b1;
      cfg_jbus_div = 5'd6;
      cfg_ddr_div  = 5'd3;
      seq("pend", 1, 1'b0, 1'b1, 1'b0, 1'b0);
      cfg_jbus_div = 5'd9;
      cfg_ddr_div  = 5'd9;
      seq("ack63", 1, 1'b0, 1'b0, 1'b0, 1'b1);
      cfg_req = 1'b0;
      seq("r63", 12, 12'b111000111000, 12'b110110110110, 12'b100000100000, 12'b0);

      // Ratios 0 and 1 run as 2; request then held high
      cfg_req      = 1'b1;
      cfg_jbus_div = 5'd0;
      cfg_ddr_div  = 5'd1;
      seq("clamp", 6, 6'b111000, 6'b110110, 6'b100000, 6'b000001);
      for (int i = 0; i < 50; i++)
         seq("hold", 1, 32'(i % 2 == 0), 32'(i % 2 == 0), 32'(i % 2 == 0), 32'd0);

      // Drop for one cycle, then a new request 3/5 is accepted
      cfg_req = 1'b0;
      seq("drop", 1, 1'b1, 1'b1, 1'b1, 1'b0);
      cfg_req      = 1'b1;
      cfg_jbus_div = 5'd3;
      cfg_ddr_div  = 5'd5;
      seq("req35", 3, 3'b010, 3'b010, 3'b010, 3'b001);
      cfg_req = 1'b0;
      seq("r35", 15, 15'b110110110110110, 15'b111001110011100,
          15'b100000000000000, 15'b0);

      // Reset two cycles into a pending request
      cfg_req      = 1'b1;
      cfg_jbus_div = 5'd6;
      cfg_ddr_div  = 5'd3;
      seq("pend2", 2, 2'b11, 2'b11, 2'b10, 2'b00);
      reset   = 1'b1;
      cfg_req = 1'b0;
      seq("rst2", 2, 2'b00, 2'b00, 2'b00, 2'b00);
      reset = 1'b0;
      seq("dflt2", 8, 8'b11001100, 8'b10101010, 8'b10001000, 8'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
